// File: rtl/serial_addsub.sv
// Bit-serial WIDTH-bit adder/subtractor with start/busy/done handshake and active-low LED outputs.
// Optional carry/borrow-in port SW_CIN is enabled by defining SERIAL_ADDSUB_CARRY_IN_EN.
module serial_addsub #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] SW_A,
    input  logic [WIDTH-1:0] SW_B,
    input  logic             SW_MODE,
    input  logic             SW_START,
`ifdef SERIAL_ADDSUB_CARRY_IN_EN
    input  logic             SW_CIN,
`endif
    output logic [WIDTH-1:0] LD_RES,
    output logic             LD_CB,
    output logic             LD_BUSY,
    output logic             LD_DONE
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic             start_q;
    logic             rise;
    logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_hold;
    logic             mode;
    logic             cb_reg, cb_hold;
    logic [CW-1:0]    cnt;
    logic             bit_a, bit_b, bit_s, bit_c;
    logic             init_cb;

    assign rise = SW_START & ~start_q;

`ifdef SERIAL_ADDSUB_CARRY_IN_EN
    assign init_cb = SW_CIN;
`else
    assign init_cb = 1'b0;
`endif

    always_comb begin
        bit_a = a_sr[0];
        bit_b = b_sr[0];
        bit_s = bit_a ^ bit_b ^ cb_reg;
        if (mode)
            bit_c = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & cb_reg);
        else
            bit_c = (bit_a & bit_b) | (cb_reg & (bit_a ^ bit_b));
    end

    always_ff @(posedge CLK) begin
        // start_q follows the switch even in reset so a switch held high
        // across reset release is not seen as a new rising edge
        start_q <= SW_START;
        if (RST) begin
            state    <= IDLE;
            a_sr     <= '0;
            b_sr     <= '0;
            res_sr   <= '0;
            res_hold <= '0;
            mode     <= 1'b0;
            cb_reg   <= 1'b0;
            cb_hold  <= 1'b0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (rise) begin
                        a_sr   <= SW_A;
                        b_sr   <= SW_B;
                        mode   <= SW_MODE;
                        cb_reg <= init_cb;
                        cnt    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    cb_reg <= bit_c;
                    res_sr <= {bit_s, res_sr[WIDTH-1:1]};
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        res_hold <= {bit_s, res_sr[WIDTH-1:1]};
                        cb_hold  <= bit_c;
                        state    <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign LD_RES  = ~res_hold;
    assign LD_CB   = ~cb_hold;
    assign LD_BUSY = ~(state == RUN);
    assign LD_DONE = ~(state == DONE);

endmodule

// File: tb/tb_serial_addsub.sv
// Directed self-checking bench for serial_addsub (WIDTH=4), hand-computed LED values.
module tb_serial_addsub;

    localparam int W = 4;

    logic         CLK = 1'b0;
    logic         RST;
    logic [W-1:0] SW_A, SW_B;
    logic         SW_MODE, SW_START;
`ifdef SERIAL_ADDSUB_CARRY_IN_EN
    logic         SW_CIN;
`endif
    logic [W-1:0] LD_RES;
    logic         LD_CB, LD_BUSY, LD_DONE;

    int checks = 0;
    int errors = 0;

    serial_addsub #(.WIDTH(W)) dut (
        .CLK(CLK), .RST(RST),
        .SW_A(SW_A), .SW_B(SW_B), .SW_MODE(SW_MODE), .SW_START(SW_START),
`ifdef SERIAL_ADDSUB_CARRY_IN_EN
        .SW_CIN(SW_CIN),
`endif
        .LD_RES(LD_RES), .LD_CB(LD_CB), .LD_BUSY(LD_BUSY), .LD_DONE(LD_DONE)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic check_leds(input string tag, input logic [W-1:0] res, input logic cb,
                              input logic busy, input logic done);
        check({tag, "_res"},  32'(LD_RES),  32'(res));
        check({tag, "_cb"},   32'(LD_CB),   32'(cb));
        check({tag, "_busy"}, 32'(LD_BUSY), 32'(busy));
        check({tag, "_done"}, 32'(LD_DONE), 32'(done));
    endtask

    // full operation: drop START, present operands, raise START, walk E0..E4
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic m, input logic [W-1:0] exp_led, input logic exp_cb);
        SW_START = 1'b0;
        tick();
        SW_A = a; SW_B = b; SW_MODE = m; SW_START = 1'b1;
        tick();
        for (int i = 0; i < W - 1; i++) begin
            check({tag, "_busy_run"}, 32'(LD_BUSY), 32'd0);
            check({tag, "_done_run"}, 32'(LD_DONE), 32'd1);
            tick();
        end
        check({tag, "_busy_last"}, 32'(LD_BUSY), 32'd0);
        tick();
        check_leds(tag, exp_led, exp_cb, 1'b1, 1'b0);
    endtask

    initial begin
        RST = 1'b1; SW_A = '0; SW_B = '0; SW_MODE = 1'b0; SW_START = 1'b1;
`ifdef SERIAL_ADDSUB_CARRY_IN_EN
        SW_CIN = 1'b0;
`endif
        tick(); tick();
        check_leds("reset", 4'b1111, 1'b1, 1'b1, 1'b1);
        RST = 1'b0;
        tick(); tick(); tick();
        check_leds("start_held", 4'b1111, 1'b1, 1'b1, 1'b1);

        run_op("add5p6", 4'd5, 4'd6, 1'b0, 4'b0100, 1'b1);
        run_op("add9p8", 4'd9, 4'd8, 1'b0, 4'b1110, 1'b0);
        run_op("sub3m5", 4'd3, 4'd5, 1'b1, 4'b0001, 1'b0);
        run_op("sub12m4", 4'd12, 4'd4, 1'b1, 4'b0111, 1'b1);

        // operand changes and a second START rise during RUN are ignored
        SW_START = 1'b0;
        tick();
        SW_A = 4'd5; SW_B = 4'd6; SW_MODE = 1'b0; SW_START = 1'b1;
        tick();
        SW_A = 4'd15; SW_START = 1'b0;
        tick();
        SW_START = 1'b1;
        tick();
        SW_MODE = 1'b1; SW_B = 4'd0;
        check("ign_busy_e2", 32'(LD_BUSY), 32'd0);
        tick();
        check("ign_busy_e3", 32'(LD_BUSY), 32'd0);
        tick();
        check_leds("ign", 4'b0100, 1'b1, 1'b1, 1'b0);
        SW_A = 4'd1; SW_B = 4'd1;
        tick(); tick();
        check_leds("hold", 4'b0100, 1'b1, 1'b1, 1'b0);

        // new run from DONE keeps old result, then reset at E2
        SW_START = 1'b0;
        tick();
        SW_A = 4'd9; SW_B = 4'd8; SW_MODE = 1'b0; SW_START = 1'b1;
        tick();
        check_leds("rerun_e0", 4'b0100, 1'b1, 1'b0, 1'b1);
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check_leds("midrst", 4'b1111, 1'b1, 1'b1, 1'b1);
        tick();
        check_leds("midrst_idle", 4'b1111, 1'b1, 1'b1, 1'b1);
        run_op("add2p2", 4'd2, 4'd2, 1'b0, 4'b1011, 1'b1);

        // reset wins over a simultaneous rise
        SW_START = 1'b0;
        tick();
        RST = 1'b1; SW_START = 1'b1;
        tick();
        RST = 1'b0;
        check_leds("rst_prio", 4'b1111, 1'b1, 1'b1, 1'b1);
        tick();
        check("rst_prio_nostart", 32'(LD_BUSY), 32'd1);

`ifdef SERIAL_ADDSUB_CARRY_IN_EN
        SW_CIN = 1'b1;
        run_op("cin7p8", 4'd7, 4'd8, 1'b0, 4'b1111, 1'b0);
        run_op("bin5m5", 4'd5, 4'd5, 1'b1, 4'b0000, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
